// File: rtl/cuenta_unos_n.sv
// cuenta_unos_n: serial bit-population counter.
// An N-bit operand (optionally inverted to count zeros) is loaded into a
// shift register and drained LSB first, one bit per clock, into an
// accumulator. With ATAJO=1 the run stops as soon as no 1s remain, so the
// latency tracks the position of the most significant 1. The result is held
// with a level `fin` flag until the next start.
module cuenta_unos_n #(
    parameter int N = 8,
    parameter bit ATAJO = 1'b1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          modo,
    input  logic [N-1:0]  Valor,
    output logic [CW-1:0] Cuenta,
    output logic          fin,
    output logic          ocupado
);

    // Operand width expressed in the accumulator/counter width, used to
    // preload the remaining-bit counter.
    localparam logic [CW-1:0] N_CW = CW'(N);

    typedef enum logic [1:0] {
        REPOSO,
        DESPLAZA,
        FIN
    } estado_t;

    estado_t       estado;
    logic [N-1:0]  q;         // shift register, drained LSB first
    logic [CW-1:0] a;         // accumulator; never exceeds N
    logic [CW-1:0] k;         // bits still to shift

    logic [N-1:0]  carga;     // operand as it will be loaded (maybe inverted)
    logic [N-1:0]  q_desp;    // shift register after one right shift
    logic [CW-1:0] a_suma;    // accumulator plus the bit leaving the register
    logic          carga_cero;
    logic          desp_cero;
    logic          ultimo;    // this shift edge is the last one of the run

    // Next-value datapath shared by the load and shift paths.
    always_comb begin
        carga      = modo ? ~Valor : Valor;
        q_desp     = q >> 1;
        a_suma     = a + CW'(q[0]);
        carga_cero = (carga == '0);
        desp_cero  = (q_desp == '0);
        // With the shortcut the run ends once no 1s are left; otherwise
        // only after all N bits have been shifted out.
        ultimo     = ATAJO ? desp_cero : (k == CW'(1));
    end

    // Control unit and datapath registers, with registered status outputs.
    always_ff @(posedge clk) begin
        // NOTE: every state register uses non-blocking assignments so all
        // of them update from the same pre-edge values; the reset is
        // synchronous, so it lives inside the clocked branch, not the list.
        if (!reset) begin
            estado  <= REPOSO;
            q       <= '0;
            a       <= '0;
            k       <= '0;
            fin     <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            case (estado)
                REPOSO, FIN: begin
                    // A start in FIN reloads exactly like a start in REPOSO;
                    // without start both states simply hold A and Q.
                    if (start) begin
                        q <= carga;
                        a <= '0;
                        k <= N_CW;
                        if (ATAJO && carga_cero) begin
                            estado  <= FIN;
                            fin     <= 1'b1;
                            ocupado <= 1'b0;
                        end else begin
                            estado  <= DESPLAZA;
                            fin     <= 1'b0;
                            ocupado <= 1'b1;
                        end
                    end
                end
                DESPLAZA: begin
                    // start, modo and Valor are deliberately ignored here.
                    a <= a_suma;
                    q <= q_desp;
                    k <= k - CW'(1);
                    if (ultimo) begin
                        estado  <= FIN;
                        fin     <= 1'b1;
                        ocupado <= 1'b0;
                    end
                end
                default: begin
                    estado  <= REPOSO;
                    fin     <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign Cuenta = a;

endmodule

// File: tb/tb_cuenta_unos_n.sv
// Directed testbench for cuenta_unos_n (N=8). Two instances share the clock,
// reset and operand inputs: one with the early-termination shortcut, one
// without; each has its own start line.
module tb_cuenta_unos_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       modo;
    logic       start1;
    logic       start0;
    logic [7:0] Valor;
    logic [3:0] cuenta1, cuenta0;
    logic       fin1, fin0, ocup1, ocup0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cuenta_unos_n #(.N(8), .ATAJO(1'b1)) dut_atajo (
        .clk     (clk),
        .reset   (reset),
        .start   (start1),
        .modo    (modo),
        .Valor   (Valor),
        .Cuenta  (cuenta1),
        .fin     (fin1),
        .ocupado (ocup1)
    );

    cuenta_unos_n #(.N(8), .ATAJO(1'b0)) dut_completo (
        .clk     (clk),
        .reset   (reset),
        .start   (start0),
        .modo    (modo),
        .Valor   (Valor),
        .Cuenta  (cuenta0),
        .fin     (fin0),
        .ocupado (ocup0)
    );

    // Pulse start for one edge (edge 0), then count edges until fin is seen.
    // Returns the edge number at which fin became visible, the number of
    // samples with ocupado high before that, fin right after edge 0, and
    // the final count. Bounded at 40 edges.
    task automatic run_op(input logic [7:0] v, input logic m, input bit sin_atajo,
                          output int edges, output int ocup_n,
                          output logic fin_e0, output logic [3:0] cnt);
        logic f, o;
        @(negedge clk);
        Valor = v;
        modo  = m;
        if (sin_atajo) start0 = 1'b1;
        else           start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        edges  = 0;
        ocup_n = 0;
        f      = sin_atajo ? fin0 : fin1;
        o      = sin_atajo ? ocup0 : ocup1;
        fin_e0 = f;
        while (!f && edges < 40) begin
            if (o) ocup_n++;
            @(posedge clk);
            #1;
            edges++;
            f = sin_atajo ? fin0 : fin1;
            o = sin_atajo ? ocup0 : ocup1;
        end
        cnt = sin_atajo ? cuenta0 : cuenta1;
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        modo   = 1'b0;
        Valor  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cuenta1 !== 4'd0 || fin1 !== 1'b0 || ocup1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_atajo: got Cuenta=%0d fin=%b ocupado=%b expected 0 0 0",
                     cuenta1, fin1, ocup1);
        end
        checks++;
        if (cuenta0 !== 4'd0 || fin0 !== 1'b0 || ocup0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_completo: got Cuenta=%0d fin=%b ocupado=%b expected 0 0 0",
                     cuenta0, fin0, ocup0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count_ones;
        int e, o;
        logic f0;
        logic [3:0] c;
        run_op(8'b1011_0010, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 8 || c !== 4'd4 || o !== 8) begin
            errors++;
            $display("FAIL ones_B2: got edge=%0d Cuenta=%0d ocupado_cycles=%0d expected 8 4 8",
                     e, c, o);
        end
        run_op(8'h04, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 3 || c !== 4'd1) begin
            errors++;
            $display("FAIL ones_04: got edge=%0d Cuenta=%0d expected 3 1", e, c);
        end
        run_op(8'h00, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 0 || c !== 4'd0 || o !== 0) begin
            errors++;
            $display("FAIL ones_00: got edge=%0d Cuenta=%0d ocupado_cycles=%0d expected 0 0 0",
                     e, c, o);
        end
        run_op(8'b0110_1001, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 7 || c !== 4'd4) begin
            errors++;
            $display("FAIL ones_69: got edge=%0d Cuenta=%0d expected 7 4", e, c);
        end
    endtask

    task automatic test_count_zeros;
        int e, o;
        logic f0;
        logic [3:0] c;
        run_op(8'h00, 1'b1, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 8 || c !== 4'd8) begin
            errors++;
            $display("FAIL zeros_00: got edge=%0d Cuenta=%0d expected 8 8", e, c);
        end
        run_op(8'hFF, 1'b1, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 0 || c !== 4'd0) begin
            errors++;
            $display("FAIL zeros_FF: got edge=%0d Cuenta=%0d expected 0 0", e, c);
        end
        // ~0xF3 = 0x0C: two zeros, most significant at bit 3
        run_op(8'hF3, 1'b1, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 4 || c !== 4'd2) begin
            errors++;
            $display("FAIL zeros_F3: got edge=%0d Cuenta=%0d expected 4 2", e, c);
        end
    endtask

    task automatic test_no_shortcut;
        int e, o;
        logic f0;
        logic [3:0] c;
        run_op(8'h01, 1'b0, 1'b1, e, o, f0, c);
        checks++;
        if (e !== 8 || c !== 4'd1 || o !== 8) begin
            errors++;
            $display("FAIL full_01: got edge=%0d Cuenta=%0d ocupado_cycles=%0d expected 8 1 8",
                     e, c, o);
        end
        run_op(8'h00, 1'b0, 1'b1, e, o, f0, c);
        checks++;
        if (e !== 8 || c !== 4'd0) begin
            errors++;
            $display("FAIL full_00: got edge=%0d Cuenta=%0d expected 8 0", e, c);
        end
        run_op(8'h5A, 1'b1, 1'b1, e, o, f0, c);
        checks++;
        if (e !== 8 || c !== 4'd4) begin
            errors++;
            $display("FAIL full_zeros_5A: got edge=%0d Cuenta=%0d expected 8 4", e, c);
        end
    endtask

    task automatic test_ignore_start;
        int e;
        @(negedge clk);
        Valor  = 8'b1011_0010;
        modo   = 1'b0;
        start1 = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        start1 = 1'b0;
        @(posedge clk);          // edge 1
        #1;
        @(negedge clk);
        Valor  = 8'hAA;
        modo   = 1'b1;
        start1 = 1'b1;
        repeat (3) @(posedge clk); // edges 2..4 with start held high
        #1;
        start1 = 1'b0;
        Valor  = 8'h00;
        modo   = 1'b0;
        e = 4;
        while (!fin1 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        checks++;
        if (e !== 8 || cuenta1 !== 4'd4) begin
            errors++;
            $display("FAIL ignore_start: got edge=%0d Cuenta=%0d expected 8 4", e, cuenta1);
        end
    endtask

    task automatic test_reset_mid;
        // Run on 0xF0, reset low at edge 3.
        @(negedge clk);
        Valor  = 8'hF0;
        modo   = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);          // edge 3
        #1;
        checks++;
        if (cuenta1 !== 4'd0 || fin1 !== 1'b0 || ocup1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_F0: got Cuenta=%0d fin=%b ocupado=%b expected 0 0 0",
                     cuenta1, fin1, ocup1);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fin1 !== 1'b0 || ocup1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got fin=%b ocupado=%b expected 0 0", fin1, ocup1);
        end
        // Run on 0xFF: the count is 2 after edge 2, reset must clear it.
        @(negedge clk);
        Valor  = 8'hFF;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cuenta1 !== 4'd2 || ocup1 !== 1'b1) begin
            errors++;
            $display("FAIL partial_FF: got Cuenta=%0d ocupado=%b expected 2 1", cuenta1, ocup1);
        end
        @(negedge clk);
        reset = 1'b0;
        start1 = 1'b1;           // reset wins over start
        @(posedge clk);
        #1;
        checks++;
        if (cuenta1 !== 4'd0 || fin1 !== 1'b0 || ocup1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_FF: got Cuenta=%0d fin=%b ocupado=%b expected 0 0 0",
                     cuenta1, fin1, ocup1);
        end
        @(negedge clk);
        start1 = 1'b0;
        reset  = 1'b1;
    endtask

    task automatic test_back_to_back;
        int e, o;
        logic f0;
        logic [3:0] c;
        run_op(8'h10, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (e !== 5 || c !== 4'd1) begin
            errors++;
            $display("FAIL first_10: got edge=%0d Cuenta=%0d expected 5 1", e, c);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (fin1 !== 1'b1 || cuenta1 !== 4'd1 || ocup1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_fin: got fin=%b Cuenta=%0d ocupado=%b expected 1 1 0",
                     fin1, cuenta1, ocup1);
        end
        run_op(8'h07, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (f0 !== 1'b0 || e !== 3 || c !== 4'd3) begin
            errors++;
            $display("FAIL restart_07: got fin_e0=%b edge=%0d Cuenta=%0d expected 0 3 3",
                     f0, e, c);
        end
        run_op(8'h00, 1'b0, 1'b0, e, o, f0, c);
        checks++;
        if (f0 !== 1'b1 || e !== 0 || c !== 4'd0) begin
            errors++;
            $display("FAIL restart_00: got fin_e0=%b edge=%0d Cuenta=%0d expected 1 0 0",
                     f0, e, c);
        end
        run_op(8'h81, 1'b0, 1'b1, e, o, f0, c);
        checks++;
        if (f0 !== 1'b0 || e !== 8 || c !== 4'd2) begin
            errors++;
            $display("FAIL restart_full_81: got fin_e0=%b edge=%0d Cuenta=%0d expected 0 8 2",
                     f0, e, c);
        end
    endtask

    initial begin
        test_reset();
        test_count_ones();
        test_count_zeros();
        test_no_shortcut();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
